// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet deframer.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DRAIN
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef logic [7:0] len_t;

  // A LEN byte of zero or beyond the buffer depth cannot be framed.
  function automatic logic is_bad_len(input len_t len, input len_t max_len);
    return (len == 8'd0) || (len > max_len);
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Single-frame payload store: one write port, one read port with
// registered read data (one clock of read latency).
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Write port; contents survive reset and error aborts.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port, re-read every clock from the presented address.
  always_ff @(posedge clk_i) begin
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_pkt_rx.sv
// Packet deframer: SYNC, LEN, LEN payload bytes, XOR checksum over LEN and
// payload. A frame is buffered until its checksum verifies, then replayed
// on a valid/ready byte stream.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | hunting for SYNC_BYTE, other bytes ignored
// ST_LEN     | next byte is the payload length
// ST_PAYLOAD | storing payload bytes and folding them into checksum
// ST_CHECK   | next byte is the checksum
// ST_DRAIN   | replaying the verified frame, incoming bytes dropped
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 8680,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Done,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Out_Valid,
  output logic [7:0] o_Out_Byte,
  output logic       o_Out_Last,
  input  logic       i_Out_Ready,
  output logic [7:0] o_Frame_Len,
  output logic       o_Err_Length,
  output logic       o_Err_Checksum,
  output logic       o_Err_Timeout,
  output logic       o_Overrun
);

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int          TW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_TC  = TW'(TIMEOUT_CLKS - 1);
  localparam len_t        MAX_LEN_B = len_t'(MAX_LEN);

  state_e        state_q;
  len_t          len_q;
  logic [7:0]    chk_q;
  len_t          wr_idx_q;
  len_t          rd_idx_q;
  logic [TW-1:0] tmo_q;
  logic          out_valid_q;
  logic          out_last_q;
  len_t          frame_len_q;
  logic          err_len_q;
  logic          err_chk_q;
  logic          err_tmo_q;
  logic          overrun_q;

  logic          handshake;
  logic          in_frame;
  logic          tmo_hit;
  logic          buf_wr_en;
  len_t          len_m1;
  len_t          rd_next;
  logic [AW-1:0] rd_addr_d;
  logic [7:0]    buf_rd_data;

  // Handshake, timeout terminal count and buffer addressing. The read
  // address moves to rd_idx+1 on a handshake so the next byte is already
  // in the read register on the following clock.
  always_comb begin
    handshake = out_valid_q & i_Out_Ready;
    in_frame  = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                (state_q == ST_CHECK);
    tmo_hit   = in_frame && !i_RX_Done && (tmo_q == TMO_TC);
    len_m1    = len_q - 8'd1;
    rd_next   = rd_idx_q + 8'd1;
    rd_addr_d = handshake ? rd_next[AW-1:0] : rd_idx_q[AW-1:0];
    buf_wr_en = !i_Rst && i_RX_Done && (state_q == ST_PAYLOAD);
  end

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i     (i_Clock),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (wr_idx_q[AW-1:0]),
    .wr_data_i (i_RX_Byte),
    .rd_addr_i (rd_addr_d),
    .rd_data_o (buf_rd_data)
  );

  // Frame FSM with checksum, timeout counter and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      chk_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_len_q <= '0;
      err_len_q   <= 1'b0;
      err_chk_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_tmo_q <= 1'b0;
      overrun_q <= 1'b0;

      // A strobe always restarts the idle count, even on terminal count.
      if (i_RX_Done || !in_frame || tmo_hit) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (i_RX_Done && (i_RX_Byte == SYNC_BYTE)) begin
            state_q <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (i_RX_Done) begin
            if (is_bad_len(i_RX_Byte, MAX_LEN_B)) begin
              err_len_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              len_q    <= i_RX_Byte;
              chk_q    <= i_RX_Byte;
              wr_idx_q <= '0;
              rd_idx_q <= '0;
              state_q  <= ST_PAYLOAD;
            end
          end else if (tmo_hit) begin
            err_tmo_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        ST_PAYLOAD: begin
          if (i_RX_Done) begin
            chk_q    <= chk_q ^ i_RX_Byte;
            wr_idx_q <= wr_idx_q + 8'd1;
            if (wr_idx_q == len_m1) begin
              state_q <= ST_CHECK;
            end
          end else if (tmo_hit) begin
            err_tmo_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        ST_CHECK: begin
          if (i_RX_Done) begin
            if (i_RX_Byte == chk_q) begin
              out_valid_q <= 1'b1;
              out_last_q  <= (len_q == 8'd1);
              frame_len_q <= len_q;
              state_q     <= ST_DRAIN;
            end else begin
              err_chk_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end else if (tmo_hit) begin
            err_tmo_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (i_RX_Done) begin
            overrun_q <= 1'b1;
          end
          if (handshake) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              frame_len_q <= '0;
              state_q     <= ST_IDLE;
            end else begin
              rd_idx_q   <= rd_next;
              out_last_q <= (rd_next == len_m1);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Out_Valid    = out_valid_q;
  assign o_Out_Byte     = out_valid_q ? buf_rd_data : 8'h00;
  assign o_Out_Last     = out_last_q;
  assign o_Frame_Len    = frame_len_q;
  assign o_Err_Length   = err_len_q;
  assign o_Err_Checksum = err_chk_q;
  assign o_Err_Timeout  = err_tmo_q;
  assign o_Overrun      = overrun_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for the UART packet deframer.
module tb_uart_pkt_rx;

  logic       i_Clock = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_RX_Done = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00;
  logic       i_Out_Ready = 1'b0;
  logic       o_Out_Valid;
  logic [7:0] o_Out_Byte;
  logic       o_Out_Last;
  logic [7:0] o_Frame_Len;
  logic       o_Err_Length;
  logic       o_Err_Checksum;
  logic       o_Err_Timeout;
  logic       o_Overrun;

  int errors = 0;
  int checks = 0;
  int n_len = 0, n_chk = 0, n_tmo = 0, n_ovr = 0, n_valid = 0;

  uart_pkt_rx #(
    .MAX_LEN      (16),
    .TIMEOUT_CLKS (8680),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .i_Clock        (i_Clock),
    .i_Rst          (i_Rst),
    .i_RX_Done      (i_RX_Done),
    .i_RX_Byte      (i_RX_Byte),
    .o_Out_Valid    (o_Out_Valid),
    .o_Out_Byte     (o_Out_Byte),
    .o_Out_Last     (o_Out_Last),
    .i_Out_Ready    (i_Out_Ready),
    .o_Frame_Len    (o_Frame_Len),
    .o_Err_Length   (o_Err_Length),
    .o_Err_Checksum (o_Err_Checksum),
    .o_Err_Timeout  (o_Err_Timeout),
    .o_Overrun      (o_Overrun)
  );

  always #5 i_Clock = ~i_Clock;

  // Pulse/valid tallies sampled mid-cycle.
  always @(negedge i_Clock) begin
    if (o_Err_Length)   n_len++;
    if (o_Err_Checksum) n_chk++;
    if (o_Err_Timeout)  n_tmo++;
    if (o_Overrun)      n_ovr++;
    if (o_Out_Valid)    n_valid++;
  end

  task automatic send_byte(input logic [7:0] b);
    i_RX_Byte = b;
    i_RX_Done = 1'b1;
    @(posedge i_Clock);
    #1;
    i_RX_Done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    idle(2);
    i_Rst = 1'b0;
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== 10'h000) begin
      errors++;
      $display("FAIL reset_out: got v=%b b=%h l=%b expected 0 00 0", o_Out_Valid, o_Out_Byte, o_Out_Last);
    end
    checks++;
    if (o_Frame_Len !== 8'h00) begin
      errors++;
      $display("FAIL reset_len: got %h expected 00", o_Frame_Len);
    end
    checks++;
    if ({o_Err_Length, o_Err_Checksum, o_Err_Timeout, o_Overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0000",
               {o_Err_Length, o_Err_Checksum, o_Err_Timeout, o_Overrun});
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] exp [3];
    int e0;
    exp = '{8'h11, 8'h22, 8'h33};
    e0 = n_len + n_chk + n_tmo + n_ovr;
    i_Out_Ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, exp[i], (i == 2)}) begin
        errors++;
        $display("FAIL good_byte%0d: got v=%b b=%h l=%b expected 1 %h %b",
                 i, o_Out_Valid, o_Out_Byte, o_Out_Last, exp[i], (i == 2));
      end
      checks++;
      if (o_Frame_Len !== 8'h03) begin
        errors++;
        $display("FAIL good_len%0d: got %h expected 03", i, o_Frame_Len);
      end
      idle(1);
    end
    checks++;
    if ({o_Out_Valid, o_Frame_Len} !== 9'h000) begin
      errors++;
      $display("FAIL good_end: got v=%b len=%h expected 0 00", o_Out_Valid, o_Frame_Len);
    end
    idle(2);
    checks++;
    if (n_len + n_chk + n_tmo + n_ovr - e0 !== 0) begin
      errors++;
      $display("FAIL good_errs: got %0d pulses expected 0", n_len + n_chk + n_tmo + n_ovr - e0);
    end
  endtask

  task automatic test_bad_checksum();
    int c0, v0;
    c0 = n_chk;
    v0 = n_valid;
    i_Out_Ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h04);
    checks++;
    if (o_Err_Checksum !== 1'b1) begin
      errors++;
      $display("FAIL badchk_pulse: got %b expected 1", o_Err_Checksum);
    end
    idle(3);
    checks++;
    if (n_chk - c0 !== 1) begin
      errors++;
      $display("FAIL badchk_count: got %0d expected 1", n_chk - c0);
    end
    checks++;
    if (n_valid - v0 !== 0) begin
      errors++;
      $display("FAIL badchk_valid: got %0d valid cycles expected 0", n_valid - v0);
    end
  endtask

  task automatic test_length_errors();
    int l0;
    l0 = n_len;
    i_Out_Ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h00);
    idle(1);
    send_byte(8'hA5); send_byte(8'h11);
    idle(1);
    checks++;
    if (n_len - l0 !== 2) begin
      errors++;
      $display("FAIL len_count: got %0d expected 2", n_len - l0);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h54);
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, 8'h55, 1'b1}) begin
      errors++;
      $display("FAIL len_recover: got v=%b b=%h l=%b expected 1 55 1", o_Out_Valid, o_Out_Byte, o_Out_Last);
    end
    idle(2);
  endtask

  task automatic test_max_len();
    i_Out_Ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, 8'(i), (i == 15)}) begin
        errors++;
        $display("FAIL maxlen_byte%0d: got v=%b b=%h l=%b expected 1 %h %b",
                 i, o_Out_Valid, o_Out_Byte, o_Out_Last, 8'(i), (i == 15));
      end
      idle(1);
    end
    checks++;
    if (o_Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL maxlen_end: got v=%b expected 0", o_Out_Valid);
    end
  endtask

  task automatic test_timeout();
    int k, t0;
    t0 = n_tmo;
    k = 0;
    i_Out_Ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    for (int c = 1; c <= 9000 && k == 0; c++) begin
      idle(1);
      if (o_Err_Timeout) k = c;
    end
    checks++;
    if (k !== 8680) begin
      errors++;
      $display("FAIL tmo_latency: got %0d clocks expected 8680", k);
    end
    idle(1);
    checks++;
    if (o_Err_Timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_width: got %b expected 0", o_Err_Timeout);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last, o_Frame_Len} !== {1'b1, 8'h7E, 1'b1, 8'h01}) begin
      errors++;
      $display("FAIL tmo_recover: got v=%b b=%h l=%b len=%h expected 1 7e 1 01",
               o_Out_Valid, o_Out_Byte, o_Out_Last, o_Frame_Len);
    end
    idle(2);
    checks++;
    if (n_tmo - t0 !== 1) begin
      errors++;
      $display("FAIL tmo_count: got %0d expected 1", n_tmo - t0);
    end
  endtask

  task automatic test_timeout_coincide();
    int t0;
    t0 = n_tmo;
    i_Out_Ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02);
    repeat (8679) @(posedge i_Clock);
    #1;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h13);
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, 8'hAA, 1'b0}) begin
      errors++;
      $display("FAIL tc_byte0: got v=%b b=%h l=%b expected 1 aa 0", o_Out_Valid, o_Out_Byte, o_Out_Last);
    end
    idle(1);
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, 8'hBB, 1'b1}) begin
      errors++;
      $display("FAIL tc_byte1: got v=%b b=%h l=%b expected 1 bb 1", o_Out_Valid, o_Out_Byte, o_Out_Last);
    end
    idle(2);
    checks++;
    if (n_tmo - t0 !== 0) begin
      errors++;
      $display("FAIL tc_count: got %0d timeouts expected 0", n_tmo - t0);
    end
  endtask

  task automatic test_backpressure();
    logic       rdy [6];
    logic [7:0] eb  [6];
    logic       el  [6];
    logic       ev  [6];
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    eb  = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h00};
    el  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    i_Out_Ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    for (int c = 0; c < 6; c++) begin
      i_Out_Ready = rdy[c];
      checks++;
      if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {ev[c], eb[c], el[c]}) begin
        errors++;
        $display("FAIL bp_cycle%0d: got v=%b b=%h l=%b expected %b %h %b",
                 c, o_Out_Valid, o_Out_Byte, o_Out_Last, ev[c], eb[c], el[c]);
      end
      idle(1);
    end
    i_Out_Ready = 1'b1;
  endtask

  task automatic test_overrun();
    int o0, l0;
    logic [7:0] exp [3];
    exp = '{8'h11, 8'h22, 8'h33};
    o0 = n_ovr;
    l0 = n_len;
    i_Out_Ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    send_byte(8'hA5); send_byte(8'h5A);
    idle(1);
    checks++;
    if (n_ovr - o0 !== 2) begin
      errors++;
      $display("FAIL ovr_count: got %0d expected 2", n_ovr - o0);
    end
    i_Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, exp[i], (i == 2)}) begin
        errors++;
        $display("FAIL ovr_byte%0d: got v=%b b=%h l=%b expected 1 %h %b",
                 i, o_Out_Valid, o_Out_Byte, o_Out_Last, exp[i], (i == 2));
      end
      if (i == 2) begin
        send_byte(8'hA5);
      end else begin
        idle(1);
      end
    end
    checks++;
    if (o_Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_end: got v=%b expected 0", o_Out_Valid);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, 8'h7E, 1'b1}) begin
      errors++;
      $display("FAIL ovr_next: got v=%b b=%h l=%b expected 1 7e 1", o_Out_Valid, o_Out_Byte, o_Out_Last);
    end
    idle(2);
    checks++;
    if ((n_ovr - o0 !== 3) || (n_len - l0 !== 0)) begin
      errors++;
      $display("FAIL ovr_final: got ovr=%0d len_err=%0d expected 3 0", n_ovr - o0, n_len - l0);
    end
  endtask

  task automatic test_noise_reset();
    int e0, v0;
    i_Out_Ready = 1'b1;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, 8'h7E, 1'b1}) begin
      errors++;
      $display("FAIL noise_frame: got v=%b b=%h l=%b expected 1 7e 1", o_Out_Valid, o_Out_Byte, o_Out_Last);
    end
    idle(2);
    e0 = n_len + n_chk + n_tmo + n_ovr;
    v0 = n_valid;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    i_Rst = 1'b1;
    idle(1);
    i_Rst = 1'b0;
    idle(3);
    checks++;
    if ((n_len + n_chk + n_tmo + n_ovr - e0 !== 0) || (n_valid - v0 !== 0)) begin
      errors++;
      $display("FAIL rst_quiet: got errs=%0d valid=%0d expected 0 0",
               n_len + n_chk + n_tmo + n_ovr - e0, n_valid - v0);
    end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hC3);
    send_byte(8'h9B);
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last, o_Frame_Len} !== {1'b1, 8'h5A, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL rst_byte0: got v=%b b=%h l=%b len=%h expected 1 5a 0 02",
               o_Out_Valid, o_Out_Byte, o_Out_Last, o_Frame_Len);
    end
    idle(1);
    checks++;
    if ({o_Out_Valid, o_Out_Byte, o_Out_Last} !== {1'b1, 8'hC3, 1'b1}) begin
      errors++;
      $display("FAIL rst_byte1: got v=%b b=%h l=%b expected 1 c3 1", o_Out_Valid, o_Out_Byte, o_Out_Last);
    end
    idle(2);
  endtask

  initial begin
    #1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_good_frame();
    test_length_errors();
    test_max_len();
    test_timeout();
    test_timeout_coincide();
    test_backpressure();
    test_overrun();
    test_noise_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_pkt_rx.md
# uart_pkt_rx

Packet deframer on the receive side of the UART. It consumes the byte strobe from the UART receiver and parses frames of the form SYNC, LEN, LEN payload bytes, XOR checksum. Each frame is buffered until its checksum verifies, then replayed to the core over a valid/ready byte stream. It is the decode end of the host-side packet encoder.

## Interface
- MAX_LEN, 16: largest accepted payload length in bytes (1..255).
- TIMEOUT_CLKS, 8680: maximum idle clocks between bytes inside a frame (10 bit times at 868 clocks/bit).
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- i_Clock  in  1  system clock.
- i_Rst  in  1  reset; one clock, synchronous, active-high.
- i_RX_Done  in  1  one-cycle strobe from the UART receiver; i_RX_Byte is valid.
- i_RX_Byte  in  8  received byte.
- o_Out_Valid  out  1  payload byte available.
- o_Out_Byte  out  8  payload byte.
- o_Out_Last  out  1  o_Out_Byte is the final byte of the frame.
- i_Out_Ready  in  1  consumer accepts the byte.
- o_Frame_Len  out  8  LEN of the frame being drained; 0 otherwise.
- o_Err_Length  out  1  one-cycle pulse: LEN was 0 or greater than MAX_LEN.
- o_Err_Checksum  out  1  one-cycle pulse: checksum mismatch.
- o_Err_Timeout  out  1  one-cycle pulse: inter-byte timeout.
- o_Overrun  out  1  one-cycle pulse: a byte arrived during DRAIN and was dropped.

## Operation
- States:
  - IDLE: on a strobe with byte == SYNC_BYTE, go to LEN. Any other byte is ignored silently.
  - LEN: if byte == 0 or byte > MAX_LEN, pulse o_Err_Length and go to IDLE. Otherwise latch len = byte, chk = byte, wr_idx = 0, and go to PAYLOAD.
  - PAYLOAD: per strobe, write buf[wr_idx] = byte, chk ^= byte, increment wr_idx. The strobe with wr_idx == len-1 moves to CHECK.
  - CHECK: if byte == chk, go to DRAIN with rd_idx = 0. Otherwise pulse o_Err_Checksum and go to IDLE.
  - DRAIN: o_Out_Valid = 1, o_Out_Byte = buf[rd_idx], o_Out_Last = (rd_idx == len-1). On valid & ready, increment rd_idx. After the handshake on the last byte, go to IDLE.
- Checksum is an 8-bit XOR over LEN and all payload bytes. The SYNC byte is excluded.
- A SYNC_BYTE value inside LEN/PAYLOAD/CHECK is treated as data. There is no resync mid-frame.
- Timeout:
  - The counter clears on every i_RX_Done and counts only in LEN, PAYLOAD and CHECK.
  - Reaching TIMEOUT_CLKS-1 pulses o_Err_Timeout and returns to IDLE.
  - If a strobe and terminal count coincide, the strobe wins: the counter clears and the byte is processed.
- Overrun: every i_RX_Done in DRAIN pulses o_Overrun and the byte is discarded. A byte arriving on the same cycle as the final handshake is also counted as overrun.
- The buffer is single frame, MAX_LEN x 8. Its contents are not cleared by reset or by errors.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame or mid-drain aborts without an error pulse.
- o_Out_Valid rises the cycle after the i_RX_Done carrying the checksum byte.
- Valid/ready rules:
  - o_Out_Byte, o_Out_Last and o_Out_Valid are registered.
  - They stay stable while valid & !ready.
  - Back-to-back handshakes give one byte per clock.
- After the last handshake, o_Out_Valid is 0 on the next cycle and a SYNC is accepted on that same cycle.
- Error pulses assert the cycle after the offending strobe or terminal count, and last exactly one cycle.
- At most one error pulse per cycle.

## Structure
- Package uart_pkt_pkg holds:
  - state encoding: IDLE, LEN, PAYLOAD, CHECK, DRAIN;
  - the default SYNC_BYTE;
  - an 8-bit length type.
- Sub-module uart_pkt_buf: MAX_LEN x 8 RAM with one write port and one read port, registered read data.
  - Read latency is hidden by pre-reading buf[rd_idx+1] on each handshake.
- The top level holds the FSM, checksum register and timeout counter.
- The timeout counter width is clog2(TIMEOUT_CLKS).

## Test plan
- Good frame: send A5 03 11 22 33 03 with ready held 1. Required: 11, 22, 33 out on consecutive clocks, o_Out_Last only with 33, o_Frame_Len = 3, no error pulses.
- Bad checksum: send A5 03 11 22 33 04. Required: one o_Err_Checksum pulse, o_Out_Valid never asserted; the good frame that follows is delivered correctly.
- Length errors: send A5 00, then A5 11 (17 > 16). Required: two o_Err_Length pulses, FSM back in IDLE after each.
- Timeout: send A5 02 AA, then idle 8680 clocks. Required: one o_Err_Timeout pulse; a subsequent A5 01 7E 7F delivers 7E with o_Out_Last set.
- Backpressure and overrun:
  - Drain the good frame with i_Out_Ready toggling 1,0,0,1. Required: each byte held stable until accepted.
  - Inject two strobes during DRAIN. Required: two o_Overrun pulses, output data unaffected.
- Noise and reset: send 00 FF 5A before A5 and confirm they are ignored. Assert i_Rst for one clock mid-PAYLOAD. Required: return to IDLE with no error pulse; the next good frame is delivered intact.
